// File: rtl/rv32imc_1p_wb.sv
// rtl/rv32imc_1p_wb.sv - single-port writeback stage with load extraction and hazard tracking
module rv32imc_1p_wb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_kind,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [2:0]  ex_funct3,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        md_done,
  input  logic [31:0] md_result,
  output logic        c_rf_write,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_dati,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        wb_err
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, WAIT_MD} state_t;

  state_t      state;
  logic [4:0]  lat_rd;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic        xfer;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic        load_ok;

  // Only IDLE can take a new instruction; everything else is waiting on a unit
  assign ex_ready = (state == IDLE);
  assign xfer     = ex_valid & ex_ready;

  // Extract and extend the addressed byte/half from the aligned memory word
  always_comb begin
    case (lat_off)
      2'd1:    ld_byte = mem_rsp_data[15:8];
      2'd2:    ld_byte = mem_rsp_data[23:16];
      2'd3:    ld_byte = mem_rsp_data[31:24];
      default: ld_byte = mem_rsp_data[7:0];
    endcase
    ld_half   = lat_off[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    load_ok   = 1'b0;
    load_data = '0;
    case (lat_funct3)
      3'b000: begin load_ok = 1'b1;          load_data = {{24{ld_byte[7]}}, ld_byte}; end
      3'b100: begin load_ok = 1'b1;          load_data = {24'd0, ld_byte};            end
      3'b001: begin load_ok = ~lat_off[0];   load_data = {{16{ld_half[15]}}, ld_half}; end
      3'b101: begin load_ok = ~lat_off[0];   load_data = {16'd0, ld_half};            end
      3'b010: begin load_ok = (lat_off == 2'd0); load_data = mem_rsp_data;            end
      default: begin load_ok = 1'b0;         load_data = '0;                          end
    endcase
  end

  // Writeback FSM; all outputs registered, write and error are one-cycle pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_rd     <= '0;
      lat_funct3 <= '0;
      lat_off    <= '0;
      c_rf_write <= 1'b0;
      rd_addr    <= '0;
      rd_dati    <= '0;
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      wb_err     <= 1'b0;
    end else begin
      c_rf_write <= 1'b0;
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      // Responses arriving when nobody is waiting for them are dropped and flagged
      wb_err     <= (mem_rsp_valid && state != WAIT_LOAD) || (md_done && state != WAIT_MD);
      case (state)
        IDLE: begin
          if (xfer) begin
            case (ex_kind)
              2'b00: begin
                if (ex_rd[4]) begin
                  wb_err <= 1'b1;
                end else if (ex_rd != 5'd0) begin
                  c_rf_write <= 1'b1;
                  rd_addr    <= ex_rd;
                  rd_dati    <= ex_result;
                end
              end
              2'b01: begin
                lat_rd     <= ex_rd;
                lat_funct3 <= ex_funct3;
                lat_off    <= ex_result[1:0];
                state      <= WAIT_LOAD;
                pend_valid <= (ex_rd != 5'd0);
                pend_rd    <= ex_rd;
              end
              2'b10: begin
                lat_rd     <= ex_rd;
                state      <= WAIT_MD;
                pend_valid <= (ex_rd != 5'd0);
                pend_rd    <= ex_rd;
              end
              default: wb_err <= 1'b1;
            endcase
          end
        end
        WAIT_LOAD: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
            if (!load_ok || lat_rd[4]) begin
              wb_err <= 1'b1;
            end else if (lat_rd != 5'd0) begin
              c_rf_write <= 1'b1;
              rd_addr    <= lat_rd;
              rd_dati    <= load_data;
              // Keep the hazard visible while the RF write is still landing
              pend_valid <= 1'b1;
              pend_rd    <= lat_rd;
            end
          end else begin
            pend_valid <= (lat_rd != 5'd0);
            pend_rd    <= lat_rd;
          end
        end
        WAIT_MD: begin
          if (md_done) begin
            state <= IDLE;
            if (lat_rd[4]) begin
              wb_err <= 1'b1;
            end else if (lat_rd != 5'd0) begin
              c_rf_write <= 1'b1;
              rd_addr    <= lat_rd;
              rd_dati    <= md_result;
              pend_valid <= 1'b1;
              pend_rd    <= lat_rd;
            end
          end else begin
            pend_valid <= (lat_rd != 5'd0);
            pend_rd    <= lat_rd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32imc_1p_wb.sv
// tb/tb_rv32imc_1p_wb.sv - scoreboard bench for rv32imc_1p_wb
module tb_rv32imc_1p_wb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_kind;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        md_done;
  logic [31:0] md_result;
  logic        c_rf_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_dati;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        wb_err;

  typedef struct {
    logic        err;
    logic [4:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  rv32imc_1p_wb dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_kind(ex_kind), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_funct3(ex_funct3),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .md_done(md_done), .md_result(md_result),
    .c_rf_write(c_rf_write), .rd_addr(rd_addr), .rd_dati(rd_dati),
    .pend_valid(pend_valid), .pend_rd(pend_rd), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    ev_t e;
    e.err = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1'b1; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] res, input logic [2:0] f3);
    chk("ex_ready_before_issue", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_kind = k; ex_rd = rd; ex_result = res; ex_funct3 = f3;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic mem_rsp(input logic [31:0] d);
    mem_rsp_valid = 1'b1; mem_rsp_data = d;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  // Scoreboard monitor: every write/error pulse must match the next expected event
  always @(negedge clk) begin
    if (!reset_n) begin
      last_addr = '0;
      last_data = '0;
    end
    if (c_rf_write === 1'b1 || wb_err === 1'b1) begin
      chk("event_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_wb_err", {31'd0, wb_err}, {31'd0, e.err});
        chk("ev_rf_write", {31'd0, c_rf_write}, {31'd0, ~e.err});
        if (!e.err) begin
          chk("ev_rd_addr", {27'd0, rd_addr}, {27'd0, e.addr});
          chk("ev_rd_dati", rd_dati, e.data);
          last_addr = e.addr;
          last_data = e.data;
        end
      end
    end else begin
      chk("hold_rd_addr", {27'd0, rd_addr}, {27'd0, last_addr});
      chk("hold_rd_dati", rd_dati, last_data);
    end
  end

  initial begin
    reset_n = 1'b0; ex_valid = 1'b0; ex_kind = '0; ex_rd = '0; ex_result = '0; ex_funct3 = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; md_done = 1'b0; md_result = '0;
    step(); step();
    chk("rst_c_rf_write", {31'd0, c_rf_write}, 32'd0);
    chk("rst_pend_valid", {31'd0, pend_valid}, 32'd0);
    chk("rst_pend_rd", {27'd0, pend_rd}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_rd_dati", rd_dati, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

    // First edge after release accepts an ALU result
    reset_n = 1'b1;
    push_wr(5'd5, 32'hDEADBEEF);
    issue(2'b00, 5'd5, 32'hDEADBEEF, 3'b000);

    // Back-to-back ALU, one write per cycle
    ex_valid = 1'b1; ex_kind = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      ex_rd = i[4:0]; ex_result = 32'h1000_0000 + i;
      push_wr(i[4:0], 32'h1000_0000 + i);
      step();
    end
    ex_valid = 1'b0;
    step();

    // LB at offset 3
    issue(2'b01, 5'd8, 32'h0000_1003, 3'b000);
    chk("lb_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("lb_pend_valid", {31'd0, pend_valid}, 32'd1);
    chk("lb_pend_rd", {27'd0, pend_rd}, 32'd8);
    push_wr(5'd8, 32'hFFFFFF80);
    mem_rsp(32'h8012_3456);
    chk("lb_wr_pend_valid", {31'd0, pend_valid}, 32'd1);
    chk("lb_wr_pend_rd", {27'd0, pend_rd}, 32'd8);
    step();
    chk("lb_after_pend_valid", {31'd0, pend_valid}, 32'd0);

    // LBU with a 5-cycle gap; an offered instruction during the gap is ignored
    issue(2'b01, 5'd9, 32'h0000_2003, 3'b100);
    ex_valid = 1'b1; ex_kind = 2'b00; ex_rd = 5'd3; ex_result = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      chk("gap_ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("gap_pend_valid", {31'd0, pend_valid}, 32'd1);
      step();
    end
    ex_valid = 1'b0;
    push_wr(5'd9, 32'h0000_0080);
    mem_rsp(32'h8012_3456);
    step();

    // LHU upper half, LH lower half sign-extended
    issue(2'b01, 5'd10, 32'h0000_3002, 3'b101);
    push_wr(5'd10, 32'h0000BEEF);
    mem_rsp(32'hBEEF_1234);
    issue(2'b01, 5'd11, 32'h0000_3000, 3'b001);
    push_wr(5'd11, 32'hFFFF8001);
    mem_rsp(32'h0000_8001);
    step();

    // Misaligned LW
    issue(2'b01, 5'd12, 32'h0000_4001, 3'b010);
    push_err();
    mem_rsp(32'h1111_2222);
    step();

    // rd outside the 16-entry file, then rd=0
    push_err();
    issue(2'b00, 5'd17, 32'h5555_5555, 3'b000);
    issue(2'b00, 5'd0, 32'h6666_6666, 3'b000);
    step();
    chk("rd0_no_write", {31'd0, c_rf_write}, 32'd0);
    chk("rd0_no_err", {31'd0, wb_err}, 32'd0);

    // MULDIV completing after 33 cycles
    issue(2'b10, 5'd7, 32'h0, 3'b000);
    for (int i = 0; i < 32; i++) begin
      chk("md_pend_valid", {31'd0, pend_valid}, 32'd1);
      chk("md_pend_rd", {27'd0, pend_rd}, 32'd7);
      step();
    end
    push_wr(5'd7, 32'h12345678);
    md_done = 1'b1; md_result = 32'h12345678;
    step();
    md_done = 1'b0;
    chk("md_wr_pend_rd", {27'd0, pend_rd}, 32'd7);
    step();
    chk("md_after_pend_valid", {31'd0, pend_valid}, 32'd0);

    // Stray md_done in IDLE, reserved kind
    push_err();
    md_done = 1'b1;
    step();
    md_done = 1'b0;
    push_err();
    issue(2'b11, 5'd4, 32'h0, 3'b000);
    step();

    // Reset while waiting on a load abandons it
    issue(2'b01, 5'd13, 32'h0000_5000, 3'b010);
    chk("pre_rst_pend_valid", {31'd0, pend_valid}, 32'd1);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_pend_valid", {31'd0, pend_valid}, 32'd0);
    chk("mid_rst_pend_rd", {27'd0, pend_rd}, 32'd0);
    chk("mid_rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("mid_rst_rd_dati", rd_dati, 32'd0);
    chk("mid_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    step();
    reset_n = 1'b1;
    push_err();
    mem_rsp(32'hCAFE_F00D);
    step(); step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
